// File: rtl/interrupt_arbiter_pkg.sv
// Shared constants and state encoding for the CPU-side interrupt arbiter.
// Default masks assume the 16-source device configuration.
package interrupt_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_GRANT = 2'd2
  } arb_state_t;

  localparam int          DEF_INT_COUNT    = 16;
  localparam logic [15:0] DEF_VECTOR_BASE  = 16'hFFDC;
  localparam logic [15:0] DEF_NMI_MASK     = 16'h8000;
  localparam logic [15:0] DEF_AUTOCLR_MASK = 16'h0000;

  // Vectors are word-spaced: source i lives at base + 2*i.
  function automatic logic [15:0] vector_of(input logic [15:0] base, input logic [15:0] idx);
    return base + {idx[14:0], 1'b0};
  endfunction

endpackage

// File: rtl/interrupt_arbiter_prio_enc.sv
// Combinational highest-set-bit encoder with a valid flag.
module int_priority_enc #(
  parameter int WIDTH = 16,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_req,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Ascending scan: the last set bit seen is the highest index.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_req[i]) begin
        o_idx   = IDX_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_arbiter.sv
// Level-interrupt arbiter: offers the highest-priority eligible request to the CPU,
// handshakes the entry sequence, and strobes a per-source clear on grant.
module interrupt_arbiter
  import interrupt_arbiter_pkg::*;
#(
  parameter int                   INT_COUNT    = DEF_INT_COUNT,
  parameter logic [15:0]          VECTOR_BASE  = DEF_VECTOR_BASE,
  parameter logic [INT_COUNT-1:0] NMI_MASK     = DEF_NMI_MASK,
  parameter logic [INT_COUNT-1:0] AUTOCLR_MASK = DEF_AUTOCLR_MASK
) (
  input  logic                 MCLK,
  input  logic                 reset,
  input  logic [INT_COUNT-1:0] INTreq,
  input  logic                 GIE,
  input  logic                 IntAccept,
  input  logic                 IntDone,
  output logic                 IntPending,
  output logic [15:0]          IntVector,
  output logic                 IntActive,
  output logic [INT_COUNT-1:0] INTclr
);

  localparam int IDX_W = (INT_COUNT > 1) ? $clog2(INT_COUNT) : 1;

  arb_state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [INT_COUNT-1:0] r_clr, w_clr_nxt;

  logic [INT_COUNT-1:0] w_eligible;
  logic [INT_COUNT-1:0] w_onehot;
  logic [IDX_W-1:0]     w_win_idx;
  logic                 w_win_vld;

  assign w_eligible = INTreq & (GIE ? {INT_COUNT{1'b1}} : NMI_MASK);
  assign w_onehot   = {{(INT_COUNT-1){1'b0}}, 1'b1} << r_idx;

  int_priority_enc #(
    .WIDTH (INT_COUNT),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .i_req   (w_eligible),
    .o_idx   (w_win_idx),
    .o_valid (w_win_vld)
  );

  always_ff @(posedge MCLK) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_clr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_clr   <= w_clr_nxt;
    end
  end

  // Accept freezes the index the CPU saw this cycle; the clear strobe is
  // registered so it lands exactly on the first GRANT cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_clr_nxt   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_vld) begin
          w_state_nxt = ST_PEND;
          w_idx_nxt   = w_win_idx;
        end
      end
      ST_PEND: begin
        if (IntAccept) begin
          w_state_nxt = ST_GRANT;
          w_clr_nxt   = AUTOCLR_MASK & w_onehot;
        end else if (!w_win_vld) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_idx_nxt   = w_win_idx;
        end
      end
      ST_GRANT: begin
        if (IntDone) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign IntPending = (r_state == ST_PEND);
  assign IntActive  = (r_state == ST_GRANT);
  assign INTclr     = r_clr;
  assign IntVector  = vector_of(VECTOR_BASE, 16'(r_idx));

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed-vector bench for interrupt_arbiter with hand-computed expectations.
module tb_interrupt_arbiter;

  logic        MCLK = 1'b0;
  logic        reset;
  logic [15:0] INTreq;
  logic        GIE;
  logic        IntAccept;
  logic        IntDone;
  logic        IntPending;
  logic [15:0] IntVector;
  logic        IntActive;
  logic [15:0] INTclr;

  int total = 0;
  int bad   = 0;

  always #5 MCLK = ~MCLK;

  interrupt_arbiter #(
    .INT_COUNT    (16),
    .VECTOR_BASE  (16'hFFDC),
    .NMI_MASK     (16'h8000),
    .AUTOCLR_MASK (16'h0020)
  ) dut (
    .MCLK       (MCLK),
    .reset      (reset),
    .INTreq     (INTreq),
    .GIE        (GIE),
    .IntAccept  (IntAccept),
    .IntDone    (IntDone),
    .IntPending (IntPending),
    .IntVector  (IntVector),
    .IntActive  (IntActive),
    .INTclr     (INTclr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle past the edge before checking.
  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic pend, input logic act,
                         input logic [15:0] vec, input logic [15:0] clr);
    chk({tag, ".pend"}, 32'(IntPending), 32'(pend));
    chk({tag, ".act"},  32'(IntActive),  32'(act));
    chk({tag, ".vec"},  32'(IntVector),  32'(vec));
    chk({tag, ".clr"},  32'(INTclr),     32'(clr));
  endtask

  initial begin
    reset = 1'b1; INTreq = '0; GIE = 1'b0; IntAccept = 1'b0; IntDone = 1'b0;
    tick(); tick();
    chk_out("rst", 0, 0, 16'hFFDC, 16'h0000);
    reset = 1'b0;

    // 1: basic request/accept/done, source 3 has no auto-clear
    GIE = 1'b1; INTreq = 16'h0008;
    tick(); chk_out("t1.pend", 1, 0, 16'hFFE2, 16'h0000);
    IntAccept = 1'b1;
    tick(); chk_out("t1.grant", 0, 1, 16'hFFE2, 16'h0000);
    IntAccept = 1'b0; INTreq = '0; IntDone = 1'b1;
    tick(); chk_out("t1.done", 0, 0, 16'hFFE2, 16'h0000);
    IntDone = 1'b0;

    // 2: preemption, then accept racing a newer higher request
    INTreq = 16'h0004;
    tick(); chk_out("t2.p2", 1, 0, 16'hFFE0, 16'h0000);
    INTreq = 16'h0204;
    tick(); chk_out("t2.p9", 1, 0, 16'hFFEE, 16'h0000);
    IntAccept = 1'b1; INTreq = 16'h1204;
    tick(); chk_out("t2.grant", 0, 1, 16'hFFEE, 16'h0000);
    IntAccept = 1'b0;
    tick(); chk_out("t2.hold", 0, 1, 16'hFFEE, 16'h0000);
    IntDone = 1'b1; INTreq = '0;
    tick(); chk_out("t2.done", 0, 0, 16'hFFEE, 16'h0000);
    IntDone = 1'b0;

    // 3: GIE off, only the NMI source is offered; dropping it withdraws the offer
    GIE = 1'b0; INTreq = 16'h8001;
    tick(); chk_out("t3.nmi", 1, 0, 16'hFFFA, 16'h0000);
    INTreq = 16'h0001;
    tick(); chk("t3.drop.pend", 32'(IntPending), 32'd0);
    tick(); chk("t3.masked.pend", 32'(IntPending), 32'd0);
    INTreq = '0; GIE = 1'b1;

    // 4: auto-clear source 5 gets a single-cycle strobe
    INTreq = 16'h0020;
    tick(); chk_out("t4.pend", 1, 0, 16'hFFE6, 16'h0000);
    IntAccept = 1'b1;
    tick(); chk_out("t4.clr", 0, 1, 16'hFFE6, 16'h0020);
    IntAccept = 1'b0; INTreq = '0;
    tick(); chk_out("t4.clr1", 0, 1, 16'hFFE6, 16'h0000);
    IntDone = 1'b1;
    tick(); chk_out("t4.done", 0, 0, 16'hFFE6, 16'h0000);
    IntDone = 1'b0;
    tick(); chk_out("t4.noreoffer", 0, 0, 16'hFFE6, 16'h0000);

    // 5: stray handshakes in IDLE, then reset during GRANT
    IntAccept = 1'b1; IntDone = 1'b1;
    tick(); chk_out("t5.stray", 0, 0, 16'hFFE6, 16'h0000);
    IntAccept = 1'b0; IntDone = 1'b0; INTreq = 16'h0020;
    tick(); chk("t5.pend", 32'(IntPending), 32'd1);
    IntAccept = 1'b1;
    tick(); chk("t5.grant", 32'(IntActive), 32'd1);
    IntAccept = 1'b0; reset = 1'b1;
    tick(); chk_out("t5.rst", 0, 0, 16'hFFDC, 16'h0000);
    reset = 1'b0; INTreq = '0;
    tick(); chk_out("t5.after", 0, 0, 16'hFFDC, 16'h0000);

    // 6: accept+done together in PEND, then request held across done
    INTreq = 16'h0080;
    tick(); chk_out("t6.pend", 1, 0, 16'hFFEA, 16'h0000);
    IntAccept = 1'b1; IntDone = 1'b1;
    tick(); chk_out("t6.grant", 0, 1, 16'hFFEA, 16'h0000);
    IntAccept = 1'b0;
    tick(); chk_out("t6.idle", 0, 0, 16'hFFEA, 16'h0000);
    IntDone = 1'b0;
    tick(); chk_out("t6.reoffer", 1, 0, 16'hFFEA, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
